uart_rx_os: RTL and testbench

Oversampling UART receiver, the receive-side counterpart of the existing transmitter. It recovers 8N1 frames from the serial line using a tick at `SAMPLING_FACTOR` × baud from the RX prescaler. It majority-votes each bit at mid-bit and delivers bytes through a valid/ready handshake. It sits between the RX baud prescaler (gated `ena`) and the display/loopback logic in the UART top level, and reports framing and overrun errors.

---
 rtl/uart_rx_os_pkg.sv | 13 +
 rtl/bit_sync.sv | 18 +
 rtl/uart_rx_os.sv | 140 ++++++++++++++
 tb/tb_uart_rx_os.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_os_pkg.sv
// Shared receiver constants and FSM state encoding for the UART RX path.
package uart_rx_os_pkg;
  localparam int SAMPLING_FACTOR = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    RXS_IDLE      = 3'd0,
    RXS_START     = 3'd1,
    RXS_DATA      = 3'd2,
    RXS_STOP      = 3'd3,
    RXS_WAIT_HIGH = 3'd4
  } rx_state_e;
endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer, resets to 1 so an idle-high line never looks like a start edge.
module bit_sync #(
  parameter int W = 1
) (
  input  logic         src_clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [1:0][W-1:0] sync_pipe;

  always_ff @(posedge src_clk) begin
    if (rst) sync_pipe <= '1;
    else     sync_pipe <= {sync_pipe[0], d};
  end

  assign q = sync_pipe[1];
endmodule

// File: rtl/uart_rx_os.sv
// Oversampling 8N1 receiver: 3-sample mid-bit majority vote, valid/ready delivery,
// framing-error and overrun pulses.
module uart_rx_os
  import uart_rx_os_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int OS        = SAMPLING_FACTOR
) (
  input  logic                 src_clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 Bit_in,
  output logic [DATA_BITS-1:0] out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 bussy
);
  localparam int TW = $clog2(OS);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] T_S0   = TW'(OS/2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(OS/2);
  localparam logic [TW-1:0] T_DEC  = TW'(OS/2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic                 rxs;
  rx_state_e            state, state_n;
  logic [TW-1:0]        tcnt, tcnt_n;
  logic [BW-1:0]        bidx, bidx_n;
  logic [1:0]           smp, smp_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 vote, dec, deliver, ferr;

  bit_sync #(.W(1)) u_sync (
    .src_clk (src_clk),
    .rst     (rst),
    .d       (Bit_in),
    .q       (rxs)
  );

  // third sample is the live synchronized line on the decision tick
  assign vote = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);
  assign dec  = (tcnt == T_DEC);

  always_comb begin
    state_n = state;
    tcnt_n  = tcnt;
    bidx_n  = bidx;
    smp_n   = smp;
    shreg_n = shreg;
    deliver = 1'b0;
    ferr    = 1'b0;
    if (ena) begin
      tcnt_n = (tcnt == T_LAST) ? '0 : tcnt + 1'b1;
      if (tcnt == T_S0) smp_n[0] = rxs;
      if (tcnt == T_S1) smp_n[1] = rxs;
      unique case (state)
        RXS_IDLE: begin
          tcnt_n = '0;
          if (!rxs) state_n = RXS_START;
        end
        RXS_START: begin
          if (dec && vote) begin
            state_n = RXS_IDLE;
            tcnt_n  = '0;
          end else if (tcnt == T_LAST) begin
            state_n = RXS_DATA;
            bidx_n  = '0;
          end
        end
        RXS_DATA: begin
          if (dec) shreg_n = {vote, shreg[DATA_BITS-1:1]};
          if (tcnt == T_LAST) begin
            if (bidx == B_LAST) state_n = RXS_STOP;
            else                bidx_n  = bidx + 1'b1;
          end
        end
        RXS_STOP: begin
          // leave at mid stop bit so a back-to-back start edge is never missed
          if (dec) begin
            tcnt_n  = '0;
            deliver = vote;
            ferr    = ~vote;
            state_n = vote ? RXS_IDLE : RXS_WAIT_HIGH;
          end
        end
        RXS_WAIT_HIGH: begin
          tcnt_n = '0;
          if (rxs) state_n = RXS_IDLE;
        end
        default: begin
          state_n = RXS_IDLE;
          tcnt_n  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge src_clk) begin
    if (rst) begin
      state <= RXS_IDLE;
      tcnt  <= '0;
      bidx  <= '0;
      smp   <= '1;
      shreg <= '0;
    end else begin
      state <= state_n;
      tcnt  <= tcnt_n;
      bidx  <= bidx_n;
      smp   <= smp_n;
      shreg <= shreg_n;
    end
  end

  always_ff @(posedge src_clk) begin
    if (rst) begin
      out       <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr;
      overrun   <= 1'b0;
      if (deliver) begin
        if (!valid || ready) begin
          out   <= shreg;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

  assign bussy = (state != RXS_IDLE);
endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: table of frames plus timed corner sequences and randomized traffic.
`timescale 1ns/1ps
module tb_uart_rx_os;
  localparam int  OS   = 16;
  localparam int  DB   = 8;
  localparam real TCLK = 10.0;
  localparam real TBIT = TCLK * 4.0 * OS;

  logic          src_clk = 1'b0;
  logic          rst     = 1'b1;
  logic          ena     = 1'b0;
  logic          Bit_in  = 1'b1;
  logic          ready   = 1'b1;
  logic [DB-1:0] out;
  logic          valid, frame_err, overrun, bussy;

  int            n_cmp = 0, n_bad = 0;
  logic [DB-1:0] rx_q[$];
  int            vld_cycles = 0, n_ferr = 0, n_ovr = 0;
  realtime       edge_t;

  typedef struct {
    logic [DB-1:0] d;
    logic          stop;
    int            exp_bytes;
    int            exp_ferr;
  } vec_t;
  vec_t vecs[5];

  uart_rx_os #(.DATA_BITS(DB), .OS(OS)) dut (
    .src_clk   (src_clk),
    .rst       (rst),
    .ena       (ena),
    .Bit_in    (Bit_in),
    .out       (out),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .bussy     (bussy)
  );

  always #5 src_clk = ~src_clk;

  initial begin : ena_gen
    int k;
    k = 0;
    forever begin
      @(posedge src_clk); #2;
      ena = (k == 3);
      k = (k + 1) % 4;
    end
  end

  always @(negedge src_clk) begin
    if (!rst) begin
      if (valid && ready) rx_q.push_back(out);
      if (valid)     vld_cycles++;
      if (frame_err) n_ferr++;
      if (overrun)   n_ovr++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] qat(input int i);
    if (i < rx_q.size()) return 32'(rx_q[i]);
    return 32'hFFFF_FFFF;
  endfunction

  task automatic wait_bussy(input logic lvl, input string name);
    int c;
    c = 0;
    while (bussy !== lvl && c < 4000) begin
      @(posedge src_clk); #3;
      c++;
    end
    check(name, 32'(bussy === lvl), 32'd1);
  endtask

  task automatic count_ena(input int n);
    int c;
    c = 0;
    while (c < n) begin
      @(posedge src_clk); #3;
      if (ena) c++;
    end
  endtask

  // spk: data bit that gets a one-tick inverted spike near mid-bit; brk: leave line low after stop
  task automatic send_frame(input logic [DB-1:0] d, input logic stop, input real tb,
                            input int spk, input bit brk);
    edge_t = $realtime;
    Bit_in = 1'b0; #(tb);
    for (int i = 0; i < DB; i++) begin
      Bit_in = d[i];
      if (i == spk) begin
        #(tb * 9.5 / OS); Bit_in = ~d[i];
        #(tb / OS);       Bit_in = d[i];
        #(tb * 5.5 / OS);
      end else begin
        #(tb);
      end
    end
    Bit_in = stop; #(tb);
    if (!brk) Bit_in = 1'b1;
  endtask

  initial begin : watchdog
    #(2ms);
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : main
    int            bq, bf, bo, bv, lat, ef;
    logic [DB-1:0] exp_q[$];
    logic [DB-1:0] d;
    logic          st;
    real           tb;

    vecs[0] = '{8'h00, 1'b1, 1, 0};
    vecs[1] = '{8'hFF, 1'b1, 1, 0};
    vecs[2] = '{8'h3C, 1'b0, 0, 1};
    vecs[3] = '{8'h81, 1'b1, 1, 0};
    vecs[4] = '{8'h55, 1'b1, 1, 0};

    repeat (4) @(posedge src_clk); #3;
    check("rst_out",       32'(out),       32'd0);
    check("rst_valid",     32'(valid),     32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun",   32'(overrun),   32'd0);
    check("rst_bussy",     32'(bussy),     32'd0);
    @(posedge src_clk); #2; rst = 1'b0;
    repeat (8) @(posedge src_clk);

    // good frame with latency measurement
    bq = rx_q.size(); bf = n_ferr; bo = n_ovr; bv = vld_cycles; lat = 0;
    fork
      send_frame(8'hA5, 1'b1, TBIT, -1, 1'b0);
      begin
        int c;
        c = 0;
        #1;
        while (!valid && c < 3000) begin
          @(negedge src_clk);
          c++;
        end
        lat = int'(($realtime - edge_t) / TCLK);
      end
    join
    check("good_latency_window", 32'(lat >= 612 && lat <= 626), 32'd1);
    #(2 * TBIT);
    check("good_bytes",  32'(rx_q.size() - bq), 32'd1);
    check("good_data",   qat(bq),               'hA5);
    check("good_vld1",   32'(vld_cycles - bv),  32'd1);
    check("good_ferr",   32'(n_ferr - bf),      32'd0);
    check("good_ovr",    32'(n_ovr - bo),       32'd0);

    for (int v = 0; v < 5; v++) begin
      bq = rx_q.size(); bf = n_ferr;
      send_frame(vecs[v].d, vecs[v].stop, TBIT, -1, 1'b0);
      #(3 * TBIT);
      check($sformatf("vec%0d_bytes", v), 32'(rx_q.size() - bq), 32'(vecs[v].exp_bytes));
      if (vecs[v].exp_bytes > 0) check($sformatf("vec%0d_data", v), qat(bq), 32'(vecs[v].d));
      check($sformatf("vec%0d_ferr", v), 32'(n_ferr - bf), 32'(vecs[v].exp_ferr));
    end

    // 3-tick glitch: start entered then abandoned
    bq = rx_q.size(); bv = vld_cycles; bf = n_ferr;
    Bit_in = 1'b0; #(12 * TCLK); Bit_in = 1'b1;
    wait_bussy(1'b1, "glitch_start_seen");
    #(20 * 4 * TCLK);
    check("glitch_bussy_low", 32'(bussy),             32'd0);
    check("glitch_no_byte",   32'(rx_q.size() - bq),  32'd0);
    check("glitch_no_valid",  32'(vld_cycles - bv),   32'd0);
    check("glitch_no_ferr",   32'(n_ferr - bf),       32'd0);

    // single-tick spike inside data bit 3
    bq = rx_q.size();
    send_frame(8'h96, 1'b1, TBIT, 3, 1'b0);
    #(3 * TBIT);
    check("spike_bytes", 32'(rx_q.size() - bq), 32'd1);
    check("spike_data",  qat(bq),               'h96);

    // framing error followed by a long break
    bq = rx_q.size(); bf = n_ferr; bv = vld_cycles;
    send_frame(8'h3C, 1'b0, TBIT, -1, 1'b1);
    #(40 * TBIT);
    check("brk_ferr_once",   32'(n_ferr - bf),      32'd1);
    check("brk_no_byte",     32'(rx_q.size() - bq), 32'd0);
    check("brk_no_valid",    32'(vld_cycles - bv),  32'd0);
    check("brk_bussy_held",  32'(bussy),            32'd1);
    Bit_in = 1'b1;
    #(2 * TBIT);
    check("brk_released",    32'(bussy),            32'd0);
    send_frame(8'h81, 1'b1, TBIT, -1, 1'b0);
    #(3 * TBIT);
    check("brk_next_bytes",  32'(rx_q.size() - bq), 32'd1);
    check("brk_next_data",   qat(bq),               'h81);
    check("brk_ferr_total",  32'(n_ferr - bf),      32'd1);

    // overrun: consumer stalled across two back-to-back frames
    @(posedge src_clk); #2; ready = 1'b0;
    bq = rx_q.size(); bo = n_ovr; bf = n_ferr;
    send_frame(8'h11, 1'b1, TBIT, -1, 1'b0);
    send_frame(8'h22, 1'b1, TBIT, -1, 1'b0);
    #(2 * TBIT);
    check("ovr_out_kept",  32'(out),               'h11);
    check("ovr_valid",     32'(valid),             32'd1);
    check("ovr_pulse",     32'(n_ovr - bo),        32'd1);
    check("ovr_ferr",      32'(n_ferr - bf),       32'd0);
    @(posedge src_clk); #2; ready = 1'b1;
    repeat (4) @(posedge src_clk); #3;
    check("ovr_drain_bytes", 32'(rx_q.size() - bq), 32'd1);
    check("ovr_drain_data",  qat(bq),               'h11);
    check("ovr_drain_valid", 32'(valid),            32'd0);

    // ready rises exactly on the cycle the second byte is delivered
    @(posedge src_clk); #2; ready = 1'b0;
    bq = rx_q.size(); bo = n_ovr;
    fork
      begin
        send_frame(8'h33, 1'b1, TBIT, -1, 1'b0);
        send_frame(8'h44, 1'b1, TBIT, -1, 1'b0);
      end
      begin
        wait_bussy(1'b1, "ovr2_f1_start");
        wait_bussy(1'b0, "ovr2_f1_end");
        wait_bussy(1'b1, "ovr2_f2_start");
        count_ena(154);
        ready = 1'b1;
      end
    join
    #(2 * TBIT);
    check("ovr2_bytes", 32'(rx_q.size() - bq), 32'd2);
    check("ovr2_first", qat(bq),               'h33);
    check("ovr2_second", qat(bq + 1),          'h44);
    check("ovr2_no_ovr", 32'(n_ovr - bo),      32'd0);

    // reset during data bit 4
    bq = rx_q.size(); bf = n_ferr; bo = n_ovr;
    fork
      send_frame(8'hF0, 1'b1, TBIT, -1, 1'b0);
      begin
        wait_bussy(1'b1, "rst_frame_start");
        count_ena(88);
        rst = 1'b1;
        repeat (2) @(posedge src_clk); #3;
        check("midrst_out",   32'(out),       32'd0);
        check("midrst_valid", 32'(valid),     32'd0);
        check("midrst_ferr",  32'(frame_err), 32'd0);
        check("midrst_ovr",   32'(overrun),   32'd0);
        check("midrst_bussy", 32'(bussy),     32'd0);
        rst = 1'b0;
      end
    join
    #(2 * TBIT);
    check("midrst_no_byte", 32'(rx_q.size() - bq), 32'd0);
    check("midrst_no_err",  32'(n_ferr - bf + n_ovr - bo), 32'd0);
    send_frame(8'h5A, 1'b1, TBIT, -1, 1'b0);
    #(3 * TBIT);
    check("midrst_next_bytes", 32'(rx_q.size() - bq), 32'd1);
    check("midrst_next_data",  qat(bq),               'h5A);

    // baud skew, +3.5% then -3.5%
    for (int s = 0; s < 2; s++) begin
      tb = (s == 0) ? TBIT / 1.035 : TBIT / 0.965;
      bq = rx_q.size(); bf = n_ferr; bo = n_ovr;
      exp_q.delete();
      for (int i = 0; i < 16; i++) begin
        d = DB'($urandom);
        exp_q.push_back(d);
        send_frame(d, 1'b1, tb, -1, 1'b0);
        #(tb);
      end
      #(2 * TBIT);
      check($sformatf("skew%0d_bytes", s), 32'(rx_q.size() - bq), 32'd16);
      for (int i = 0; i < 16; i++)
        check($sformatf("skew%0d_data%0d", s, i), qat(bq + i), 32'(exp_q[i]));
      check($sformatf("skew%0d_ferr", s), 32'(n_ferr - bf), 32'd0);
      check($sformatf("skew%0d_ovr", s),  32'(n_ovr - bo),  32'd0);
    end

    // random bytes with occasional bad stop bits against a byte-level model
    bq = rx_q.size(); bf = n_ferr; ef = 0;
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      d  = DB'($urandom);
      st = ($urandom_range(3) != 0);
      if (st) exp_q.push_back(d);
      else    ef++;
      send_frame(d, st, TBIT, -1, 1'b0);
      #(TBIT);
    end
    #(2 * TBIT);
    check("rnd_bytes", 32'(rx_q.size() - bq), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("rnd_data%0d", i), qat(bq + i), 32'(exp_q[i]));
    check("rnd_ferr", 32'(n_ferr - bf), 32'(ef));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
